sha256_padder: RTL
==================

SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 61, width of the message byte counter; the bit length is {count,3'b000} zero-extended to 64 bits.
REQ-002 SHALL have ports clk input 1 (clock) and reset_n input 1 (reset): reset reset_n, synchronous, active-low; clock clk.
REQ-003 SHALL have in_valid input 1, message word offered.
REQ-004 SHALL have in_ready output 1, word accepted on a clk edge with in_valid&in_ready.
REQ-005 SHALL have in_data input 32, big-endian bytes, first byte in [31:24].
REQ-006 SHALL have in_last input 1, final word of the message.
REQ-007 SHALL have in_bytes input 3, valid bytes in the word (0..4); values >4 are treated as 4; 0 is legal only with in_last.
REQ-008 SHALL have blk_valid output 1, padded block offered.
REQ-009 SHALL have blk_ready input 1, consumer takes the block on an edge with blk_valid&blk_ready.
REQ-010 SHALL have blk_data output 512, word0 in [511:480] through word15 in [31:0].
REQ-011 SHALL have blk_first output 1, first block of a message; the consumer issues init when set and next otherwise.
REQ-012 SHALL have blk_last output 1, final block of the message.

Function
REQ-013 SHALL implement FSM states FILL, EMIT and PADBLK; in_ready SHALL equal (state==FILL).
REQ-014 In FILL, each accepted word SHALL be stored at word index widx (0..15), add in_bytes to the byte count, and increment widx.
REQ-015 Accepting the 16th word without in_last SHALL move to EMIT with blk_last=0; blk_valid SHALL be 1 on the next cycle.
REQ-016 Accepting an in_last word SHALL zero the invalid bytes of that word and write 0x80 at the first free byte position (next word if in_bytes=4); all later words SHALL be zero.
REQ-017 If the final byte count mod 64 is at most 55, words 14/15 SHALL be len[63:32]/len[31:0], blk_last SHALL be 1, and the FSM SHALL go to EMIT.
REQ-018 Otherwise the current block SHALL be emitted with blk_last=0, then PADBLK SHALL load a second block: zeros, 0x80000000 in word0 if 0x80 was not yet placed, length in words 14/15, blk_first=0, blk_last=1.
REQ-019 The full padded block SHALL be registered on the accepting edge, so latency from the accepting edge to blk_valid=1 is 1 cycle.
REQ-020 blk_data, blk_first and blk_last SHALL remain stable while blk_valid=1 and blk_ready=0.
REQ-021 A block handshake in EMIT SHALL go to PADBLK if a length block is pending, else to FILL; after a blk_last handshake, widx, count and the 0x80-placed flag SHALL clear and blk_first SHALL re-arm to 1.
REQ-022 blk_valid SHALL fall the cycle after the handshake; the second block of REQ-018 SHALL appear with blk_valid=1 exactly one cycle later.
REQ-023 The byte counter SHALL wrap modulo 2^LEN_W without error indication.
REQ-024 in_valid SHALL be ignored outside FILL; no input word is accepted while a block is held.

Reset
REQ-025 With reset_n=0 at an edge, the block SHALL set state=FILL, widx=0, count=0, blk_valid=0, blk_data=0, blk_first=1 (internal, visible on the next block), and blk_last=0.
REQ-026 A reset mid-message or mid-emission SHALL discard all partial data; the next message SHALL start clean.

Structure
REQ-027 Package sha256_pkg SHALL hold BLOCK_WORDS=16, PAD_BYTE=8'h80, LEN_HI_WORD=14, LEN_LO_WORD=15, MAX_FILL_BYTES=55, and the FSM state enum.
REQ-028 One combinational sub-module, sha256_pad_word, SHALL map (in_data, in_bytes, in_last) to the masked/0x80-inserted word plus a pad_placed flag.

Verification
REQ-029 "abc" test: 0x61626300, in_bytes=3, last -> one block; word0=0x61626380, words1-14=0, word15=0x00000018; first=1, last=1; SHA-256 digest ba7816bf... via the core.
REQ-030 Empty message test: in_bytes=0, last -> word0=0x80000000, words1-15=0, first=1, last=1.
REQ-031 56-byte message test (14 full words, last) -> block1: word14=0x80000000, word15=0, last=0; block2: all zero except word15=0x000001C0, first=0, last=1.
REQ-032 64-byte message test -> block1 = data, last=0; block2: word0=0x80000000, word15=0x00000200, last=1.
REQ-033 Backpressure test: blk_ready=0 for 10 cycles -> blk_data stable and in_ready=0 throughout; handshake on cycle 11 -> in_ready=1 next cycle.
REQ-034 Reset test: reset_n=0 after 5 accepted words -> blk_valid=0; then send "abc" -> first=1, word15=0x00000018.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and byte-count helper for the SHA-256
// message padder.
package sha256_pkg;

    localparam int         BLOCK_WORDS    = 16;
    localparam logic [7:0] PAD_BYTE       = 8'h80;
    localparam int         LEN_HI_WORD    = 14;
    localparam int         LEN_LO_WORD    = 15;
    localparam int         MAX_FILL_BYTES = 55;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_PADBLK = 2'd2
    } state_e;

    // Byte counts above four are treated as a full word.
    function automatic logic [2:0] clamp_bytes(input logic [2:0] bytes);
        return (bytes > 3'd4) ? 3'd4 : bytes;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Combinational word shaper: on the final word it clears the unused bytes
// and drops the 0x80 marker into the first free byte slot.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes,
    input  logic        in_last,
    output logic [31:0] word_o,
    output logic        pad_placed_o
);

    logic [2:0] bytes_eff;

    assign bytes_eff = clamp_bytes(in_bytes);

    always_comb begin
        word_o       = in_data;
        pad_placed_o = 1'b0;
        if (in_last) begin
            pad_placed_o = 1'b1;
            unique case (bytes_eff)
                3'd0:    word_o = {PAD_BYTE, 24'h000000};
                3'd1:    word_o = {in_data[31:24], PAD_BYTE, 16'h0000};
                3'd2:    word_o = {in_data[31:16], PAD_BYTE, 8'h00};
                3'd3:    word_o = {in_data[31:8], PAD_BYTE};
                default: begin
                    // A full final word leaves the marker to the next word.
                    word_o       = in_data;
                    pad_placed_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// Streams 32-bit message words into 512-bit SHA-256 blocks, appending the
// 0x80 marker, zero fill and 64-bit bit length (with an extra block if needed).
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 61
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    state_e             state_q;
    logic [3:0]         widx_q;
    logic [LEN_W-1:0]   count_q;
    logic               pad_placed_q;
    logic               len_pending_q;
    logic               blk_valid_q;
    logic               blk_first_q;
    logic               blk_last_q;

    logic [2:0]         bytes_eff;
    logic [31:0]        pw_word;
    logic               pw_placed;
    logic               accept;
    logic [LEN_W-1:0]   count_d;
    logic [LEN_W-1:0]   len_src;
    logic [63:0]        len_bits;
    logic [6:0]         blk_pos;
    logic               fits;
    logic               pad_next;

    sha256_pad_word u_pad_word (
        .in_data      (in_data),
        .in_bytes     (in_bytes),
        .in_last      (in_last),
        .word_o       (pw_word),
        .pad_placed_o (pw_placed)
    );

    assign bytes_eff = clamp_bytes(in_bytes);
    assign accept    = (state_q == ST_FILL) && in_valid;
    assign count_d   = count_q + LEN_W'(bytes_eff);

    // The length block reuses count_q, which still holds the final count.
    assign len_src   = (state_q == ST_PADBLK) ? count_q : count_d;
    assign len_bits  = 64'({len_src, 3'b000});

    // Position within this block decides the fit, so an exactly full block
    // (count a multiple of 64) still gets its own length block.
    assign blk_pos   = {1'b0, widx_q, 2'b00} + 7'(bytes_eff);
    assign fits      = (blk_pos <= 7'(MAX_FILL_BYTES));
    assign pad_next  = (bytes_eff == 3'd4);

    assign in_ready  = (state_q == ST_FILL);
    assign blk_valid = blk_valid_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;

    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word
        logic [31:0] word_q;
        logic [31:0] word_d;

        always_comb begin
            word_d = word_q;
            if (state_q == ST_PADBLK) begin
                if (gi == 0 && !pad_placed_q) begin
                    word_d = {PAD_BYTE, 24'h000000};
                end else if (gi == LEN_HI_WORD) begin
                    word_d = len_bits[63:32];
                end else if (gi == LEN_LO_WORD) begin
                    word_d = len_bits[31:0];
                end else begin
                    word_d = '0;
                end
            end else if (accept) begin
                if (4'(gi) == widx_q) begin
                    word_d = pw_word;
                end else if (in_last && (4'(gi) > widx_q)) begin
                    if (pad_next && (5'(gi) == ({1'b0, widx_q} + 5'd1))) begin
                        word_d = {PAD_BYTE, 24'h000000};
                    end else if (fits && gi == LEN_HI_WORD) begin
                        word_d = len_bits[63:32];
                    end else if (fits && gi == LEN_LO_WORD) begin
                        word_d = len_bits[31:0];
                    end else begin
                        word_d = '0;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end

        assign blk_data[511-32*gi -: 32] = word_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_FILL;
            widx_q        <= '0;
            count_q       <= '0;
            pad_placed_q  <= 1'b0;
            len_pending_q <= 1'b0;
            blk_valid_q   <= 1'b0;
            blk_first_q   <= 1'b1;
            blk_last_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        widx_q  <= widx_q + 4'd1;
                        count_q <= count_d;
                        if (in_last) begin
                            pad_placed_q  <= pw_placed || (widx_q != 4'd15);
                            len_pending_q <= !fits;
                            blk_last_q    <= fits;
                            blk_valid_q   <= 1'b1;
                            state_q       <= ST_EMIT;
                        end else if (widx_q == 4'd15) begin
                            blk_last_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            state_q     <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (blk_ready) begin
                        blk_valid_q <= 1'b0;
                        if (len_pending_q) begin
                            len_pending_q <= 1'b0;
                            blk_first_q   <= 1'b0;
                            state_q       <= ST_PADBLK;
                        end else if (blk_last_q) begin
                            widx_q       <= '0;
                            count_q      <= '0;
                            pad_placed_q <= 1'b0;
                            blk_first_q  <= 1'b1;
                            state_q      <= ST_FILL;
                        end else begin
                            blk_first_q <= 1'b0;
                            state_q     <= ST_FILL;
                        end
                    end
                end
                ST_PADBLK: begin
                    blk_valid_q <= 1'b1;
                    blk_last_q  <= 1'b1;
                    state_q     <= ST_EMIT;
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

endmodule
